// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
// Parametrised barrel shifter, one register stage per mux level.
// Modes: 00 ROL, 01 ROR, 10 SLL, 11 SRA. Latency SHAMT_W cycles, 1 op/cycle.
// Stage s applies a shift of 2^(SHAMT_W-1-s) when that bit of k is set.
// Whole pipeline freezes when the output holds a result the consumer refuses.
// Optional: define BSHIFT_CARRY_EN to add o_carry (last bit shifted out).
module pipelined_barrel_shifter #(
  parameter  int DATA_W  = 8,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_A,
  input  logic [SHAMT_W-1:0] i_k,
  input  logic [1:0]        i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_Y
`ifdef BSHIFT_CARRY_EN
  ,
  output logic              o_carry
`endif
);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;

  logic [DATA_W-1:0]  data_q  [SHAMT_W];
  logic [SHAMT_W-1:0] k_q     [SHAMT_W];
  logic [1:0]         mode_q  [SHAMT_W];
  logic               valid_q [SHAMT_W];
`ifdef BSHIFT_CARRY_EN
  logic               carry_q [SHAMT_W];
`endif

  logic stall;

  // Output register holds a result the consumer is not taking: freeze everything.
  assign stall   = valid_q[SHAMT_W-1] & ~i_ready;
  assign o_ready = ~stall;
  assign o_valid = valid_q[SHAMT_W-1];
  assign o_Y     = data_q[SHAMT_W-1];
`ifdef BSHIFT_CARRY_EN
  assign o_carry = carry_q[SHAMT_W-1];
`endif

  // The tail stage's k and mode have no consumer once the last shift is applied.
  logic unused_tail;
  assign unused_tail = ^{k_q[SHAMT_W-1], mode_q[SHAMT_W-1]};

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int BIT = SHAMT_W - 1 - s;
    localparam int AMT = 1 << BIT;

    logic [DATA_W-1:0]  d_in;
    logic [DATA_W-1:0]  d_shift;
    logic [SHAMT_W-1:0] k_in;
    logic [1:0]         mode_in;
    logic               v_in;

    if (s == 0) begin : g_head
      assign d_in    = i_A;
      assign k_in    = i_k;
      assign mode_in = i_mode;
      assign v_in    = i_valid;
    end else begin : g_link
      assign d_in    = data_q[s-1];
      assign k_in    = k_q[s-1];
      assign mode_in = mode_q[s-1];
      assign v_in    = valid_q[s-1];
    end

    // Fixed-distance shift for this level in the requested mode.
    always_comb begin
      d_shift = d_in;
      case (mode_in)
        MODE_ROL: d_shift = {d_in[DATA_W-AMT-1:0], d_in[DATA_W-1:DATA_W-AMT]};
        MODE_ROR: d_shift = {d_in[AMT-1:0], d_in[DATA_W-1:AMT]};
        MODE_SLL: d_shift = {d_in[DATA_W-AMT-1:0], {AMT{1'b0}}};
        default:  d_shift = {{AMT{d_in[DATA_W-1]}}, d_in[DATA_W-1:AMT]};
      endcase
    end

    // Stage register: advance unless the output is stalled.
    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        data_q[s]  <= '0;
        k_q[s]     <= '0;
        mode_q[s]  <= '0;
        valid_q[s] <= 1'b0;
      end else if (!stall) begin
        data_q[s]  <= k_in[BIT] ? d_shift : d_in;
        k_q[s]     <= k_in;
        mode_q[s]  <= mode_in;
        valid_q[s] <= v_in;
      end
    end

`ifdef BSHIFT_CARRY_EN
    logic c_in;
    logic c_shift;

    if (s == 0) begin : g_c_head
      assign c_in = 1'b0;
    end else begin : g_c_link
      assign c_in = carry_q[s-1];
    end

    // Bit leaving the word at this level; the last level that shifts wins.
    always_comb begin
      c_shift = 1'b0;
      case (mode_in)
        MODE_ROL: c_shift = d_shift[0];
        MODE_ROR: c_shift = d_shift[DATA_W-1];
        MODE_SLL: c_shift = d_in[DATA_W-AMT];
        default:  c_shift = d_in[AMT-1];
      endcase
    end

    // Carry register moves in lock-step with the data register.
    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        carry_q[s] <= 1'b0;
      end else if (!stall) begin
        carry_q[s] <= k_in[BIT] ? c_shift : c_in;
      end
    end
`endif
  end

endmodule
